// File: rtl/ppr_pkg.sv
// ppr_pkg: shared types for the PPR top-K selector.
// List entries and the scan/stream state encoding live here.
package ppr_pkg;

    localparam int PPR_SCORE_W = 32;
    localparam int PPR_ID_W    = 16;

    typedef struct packed {
        logic                   valid;
        logic [PPR_SCORE_W-1:0] score;
        logic [PPR_ID_W-1:0]    id;
    } topk_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        OUT
    } topk_state_t;

endpackage

// File: rtl/ppr_topk_select_slot.sv
// topk_slot: one cell of the sorted top-K list.
// A candidate lands in the first cell that is empty or holds a strictly
// smaller score; every cell below that point takes its upper neighbour.
module topk_slot
    import ppr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        ins_en,
    input  topk_entry_t cand,
    input  topk_entry_t upper,
    input  logic        upper_ins,
    output topk_entry_t entry,
    output logic        ins
);

    // Candidate belongs at or above this cell; equal scores keep the incumbent.
    always_comb begin
        ins = upper_ins || !entry.valid || (cand.score > entry.score);
    end

    // Shift from the upper neighbour, take the candidate, or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry <= '0;
        end else if (clr) begin
            entry <= '0;
        end else if (ins_en) begin
            if (upper_ins) begin
                entry <= upper;
            end else if (ins) begin
                entry <= cand;
            end
        end
    end

endmodule

// File: rtl/ppr_topk_select.sv
// ppr_topk_select: scans every score-sum bank after the global finish,
// keeps a sorted top-K (score, node id) list and streams it out rank 0 first.
// Optional build macro: TOPK_SKIP_ZERO_EN (zero scores are never inserted).
module ppr_topk_select
    import ppr_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 13,
    parameter int PARALLEL      = 16,
    parameter int node_num      = 5,
    parameter int last_node_num = 5,
    parameter int K             = 8,
    parameter int ID_WIDTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [ADDR_WIDTH*PARALLEL-1:0] score_addr,
    input  logic [DATA_WIDTH*PARALLEL-1:0] score_data,
    output logic                           busy,
    output logic                           done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_score,
    output logic [ID_WIDTH-1:0]            out_id,
    output logic                           out_last
);

    localparam int BW = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;
    localparam int CW = $clog2(K + 1);

    topk_state_t           state, state_nx;
    logic [BW-1:0]         bank, bank_d;
    logic [ADDR_WIDTH-1:0] addr, addr_d, addr_max;
    logic                  issue, iss_d;
    logic                  scan_last, addr_wrap;
    logic [CW-1:0]         fill_cnt, rd_idx;
    logic [DATA_WIDTH-1:0] cand_raw;
    logic [ID_WIDTH-1:0]   cand_id;
    topk_entry_t           cand, sel;
    logic                  ins_en, clr;
    topk_entry_t           ent [K];
    logic [K-1:0]          ins_flag;

    // Scan limits: the last bank may hold fewer nodes.
    always_comb begin
        addr_max  = (bank == BW'(PARALLEL - 1)) ? ADDR_WIDTH'(last_node_num - 1)
                                                : ADDR_WIDTH'(node_num - 1);
        addr_wrap = (addr == addr_max);
        scan_last = (bank == BW'(PARALLEL - 1)) && addr_wrap;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (scan_last) state_nx = FLUSH;
            FLUSH:   state_nx = OUT;
            OUT:     if (fill_cnt == '0 || (out_valid && out_ready && out_last)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state and the read pointer; out_ready only moves rd_idx.
    always_comb begin
        busy       = (state != IDLE);
        issue      = (state == SCAN);
        clr        = (state == IDLE);
        out_valid  = (state == OUT) && (rd_idx < fill_cnt) && sel.valid;
        out_last   = out_valid && (rd_idx == fill_cnt - CW'(1));
        out_score  = out_valid ? DATA_WIDTH'(sel.score) : '0;
        out_id     = out_valid ? ID_WIDTH'(sel.id) : '0;
        score_addr = {PARALLEL{addr}};
    end

    // Scan counters, one-cycle read-latency alignment, fill count and stream pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank     <= '0;
            addr     <= '0;
            iss_d    <= 1'b0;
            bank_d   <= '0;
            addr_d   <= '0;
            fill_cnt <= '0;
            rd_idx   <= '0;
            done     <= 1'b0;
        end else begin
            iss_d  <= issue;
            bank_d <= bank;
            addr_d <= addr;
            done   <= (state == OUT) && (state_nx == IDLE);
            if (ins_en && fill_cnt != CW'(K)) begin
                fill_cnt <= fill_cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    bank     <= '0;
                    addr     <= '0;
                    fill_cnt <= '0;
                    rd_idx   <= '0;
                end
                SCAN: begin
                    if (addr_wrap) begin
                        addr <= '0;
                        if (!scan_last) begin
                            bank <= bank + BW'(1);
                        end
                    end else begin
                        addr <= addr + ADDR_WIDTH'(1);
                    end
                end
                OUT: begin
                    if (out_valid && out_ready) begin
                        rd_idx <= rd_idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Candidate from the bank addressed one cycle earlier.
    always_comb begin
        cand_raw = '0;
        for (int unsigned b = 0; b < PARALLEL; b++) begin
            if (bank_d == BW'(b)) begin
                cand_raw = score_data[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        cand_id     = ID_WIDTH'(bank_d) * ID_WIDTH'(node_num) + ID_WIDTH'(addr_d);
        cand        = '0;
        cand.valid  = 1'b1;
        cand.score  = PPR_SCORE_W'(cand_raw);
        cand.id     = PPR_ID_W'(cand_id);
    end

`ifdef TOPK_SKIP_ZERO_EN
    // Insert only returned reads carrying a nonzero score.
    always_comb begin
        ins_en = iss_d && (cand_raw != '0);
    end
`else
    // Insert every returned read.
    always_comb begin
        ins_en = iss_d;
    end
`endif

    // Rank selection for the stream output.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (rd_idx == CW'(i)) begin
                sel = ent[i];
            end
        end
    end

    // Insertion chain: each cell sees its upper neighbour's entry and flag.
    for (genvar g = 0; g < K; g++) begin : g_slot
        topk_entry_t up_e;
        logic        up_i;
        if (g == 0) begin : g_head
            // Head cell has nothing above it.
            always_comb begin
                up_e = '0;
                up_i = 1'b0;
            end
        end else begin : g_body
            // Link to the cell one rank higher.
            always_comb begin
                up_e = ent[g-1];
                up_i = ins_flag[g-1];
            end
        end
        topk_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .ins_en    (ins_en),
            .cand      (cand),
            .upper     (up_e),
            .upper_ins (up_i),
            .entry     (ent[g]),
            .ins       (ins_flag[g])
        );
    end

endmodule
